// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the 32-entry regfile plus destination busy scoreboard.
// 1-cycle grant-to-we_po latency, no output back-pressure; WB_R0_DISCARD_EN makes R0 writes/reservations no-ops.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int REG_W   = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk_pi,
  input  logic                      reset_n_pi,
  input  logic [NUM_REQ-1:0]        valid_pi,
  input  logic [NUM_REQ*REG_W-1:0]  destReg_pi,
  input  logic [NUM_REQ*DATA_W-1:0] data_pi,
  output logic [NUM_REQ-1:0]        ready_po,
  input  logic                      reserve_pi,
  input  logic [REG_W-1:0]          reserveReg_pi,
  input  logic [REG_W-1:0]          reg1_pi,
  input  logic [REG_W-1:0]          reg2_pi,
  output logic                      busy1_po,
  output logic                      busy2_po,
  output logic                      we_po,
  output logic [REG_W-1:0]          destReg_po,
  output logic [DATA_W-1:0]         writeData_po
);

  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_REGS = 1 << REG_W;

  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                we_q, we_d;
  logic [REG_W-1:0]    dest_q, dest_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic                gnt_vld;
  int                  gnt_sel;
  int                  search_idx;
  int                  ptr_nxt;
  logic [REG_W-1:0]    gnt_dest;
  logic [DATA_W-1:0]   gnt_data;

  // First valid requester at or after ptr, wrapping, wins.
  always_comb begin
    gnt_vld    = 1'b0;
    gnt_sel    = 0;
    search_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      search_idx = int'(ptr_q) + k;
      if (search_idx >= NUM_REQ) search_idx = search_idx - NUM_REQ;
      if (!gnt_vld && valid_pi[search_idx]) begin
        gnt_vld = 1'b1;
        gnt_sel = search_idx;
      end
    end
  end

  always_comb begin
    ready_po = '0;
    gnt_dest = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_vld && (i == gnt_sel)) begin
        ready_po[i] = 1'b1;
        gnt_dest    = destReg_pi[i*REG_W +: REG_W];
        gnt_data    = data_pi[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_nxt = gnt_sel + 1;
    if (ptr_nxt >= NUM_REQ) ptr_nxt = 0;
    ptr_d = gnt_vld ? PTR_W'(ptr_nxt) : ptr_q;

`ifdef WB_R0_DISCARD_EN
    we_d = gnt_vld && (gnt_dest != '0);
`else
    we_d = gnt_vld;
`endif
    dest_d = dest_q;
    data_d = data_q;
    if (we_d) begin
      dest_d = gnt_dest;
      data_d = gnt_data;
    end
  end

  // Clear on the edge the regfile captures the write; a same-edge reservation is younger and wins.
  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[dest_q] = 1'b0;
`ifdef WB_R0_DISCARD_EN
    if (reserve_pi && (reserveReg_pi != '0)) busy_d[reserveReg_pi] = 1'b1;
`else
    if (reserve_pi) busy_d[reserveReg_pi] = 1'b1;
`endif
  end

  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      ptr_q  <= '0;
      we_q   <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      dest_q <= dest_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign we_po        = we_q;
  assign destReg_po   = dest_q;
  assign writeData_po = data_q;

`ifdef WB_R0_DISCARD_EN
  assign busy1_po = (reg1_pi != '0) && busy_q[reg1_pi];
  assign busy2_po = (reg2_pi != '0) && busy_q[reg2_pi];
`else
  assign busy1_po = busy_q[reg1_pi];
  assign busy2_po = busy_q[reg2_pi];
`endif

endmodule
